imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the instruction memory: accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and drives a single-cycle write port into the instruction store that the CPU fetch path reads. While loading it holds the CPU in reset through `cpu_hold`. It releases the CPU only after the declared number of words has been written.

## Interface
- `WORDSIZE`, default 32: data word width; fixed at 32 (4 bytes per word).
- `DEPTH`, default 1024: instruction store depth in words; equals `ROM_COL_MAX`.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-low; asserted (0) forces all state to reset values immediately.
- `in_data` input 8: stream byte.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: loader accepts a byte this cycle.
- `restart` input 1: return to IDLE from DONE or ERR.
- `mem_we` output 1: write strobe to the instruction store, one cycle per word.
- `mem_addr` output 32: word index for the write (same indexing as the fetch `read_addr`).
- `mem_wdata` output 32: word to write.
- `words_loaded` output 32: count of words written since the last IDLE.
- `done` output 1: load complete.
- `error` output 1: declared length exceeds `DEPTH`.
- `cpu_hold` output 1: keep CPU in reset.

## Operation
- A byte is accepted on a rising edge where `in_valid && in_ready`; `in_data` is ignored otherwise.
- Stream format:
  - Bytes 0–3 give the word count N, little-endian (byte 0 = bits 7:0).
  - N words follow, each 4 bytes little-endian.
- Word assembly: an internal 2-bit byte index `bidx` and a 32-bit shift register. The byte with `bidx`=k lands in bits 8k+7:8k. `bidx` wraps 3→0 on each completed word.
- States:
  - IDLE: `in_ready`=0, `cpu_hold`=1. Goes unconditionally to LEN on the next edge.
  - LEN: `in_ready`=1. On the 4th accepted byte, N is latched.
    - N=0 → DONE.
    - N>`DEPTH` → ERR.
    - Otherwise → DATA.
  - DATA: `in_ready`=1. On each 4th accepted byte, a write is issued, with `mem_addr` = `words_loaded` before the increment. After the write with index N-1, the next state is DONE.
  - DONE: `in_ready`=0, `done`=1, `cpu_hold`=0. Goes to IDLE when `restart`=1.
  - ERR: `in_ready`=0, `error`=1, `cpu_hold`=1. Goes to IDLE when `restart`=1.
- `restart` is ignored in IDLE, LEN and DATA.
- On entering IDLE:
  - `words_loaded`, `bidx` and the latched N clear to 0.
  - Store contents are not touched.
- `in_ready` is a decode of the state only. It must never depend combinationally on `in_valid`.
- Bytes offered in DONE or ERR are not accepted. The upstream holds them.

## Timing
- Reset values, during assertion and at release:
  - State IDLE.
  - `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `words_loaded`=0, `done`=0, `error`=0, `cpu_hold`=1.
- First edge after reset release: IDLE→LEN. `in_ready` rises one cycle after release.
- Write latency: `mem_we`=1 for exactly one cycle, in the cycle after the edge that accepted the word's 4th byte.
  - `mem_addr` and `mem_wdata` are registered and valid in that same cycle.
  - `words_loaded` increments on the edge that ends the write cycle.
- Throughput: one byte per cycle sustained; the loader never stalls in DATA. With `in_valid` held high, a word is written every 4 cycles.
- The DATA→DONE transition takes effect on the same edge that ends the last write cycle. `done`=1 and `cpu_hold`=0 in the following cycle; `words_loaded`=N at that point.
- LEN→ERR or LEN→DONE (N=0) on the edge accepting byte 3. No `mem_we` pulse occurs.
- Reset asserted mid-load:
  - The current write pulse is abandoned.
  - Outputs return to reset values asynchronously.
  - The partial word is discarded.
- Address never exceeds `DEPTH`-1; ERR guarantees this.

## Test plan
- Nominal load:
  - Stimulus: stream 02 00 00 00, then 13 00 00 00, then 93 00 10 00, with `in_valid` constant.
  - Required response: writes (addr 0, 0x00000013) then (addr 1, 0x00100093), 4 cycles apart. Then `done`=1, `cpu_hold`=0, `words_loaded`=2.
- Throttled source:
  - Stimulus: same stream with `in_valid` toggled pseudo-randomly.
  - Required response: identical writes and data; exactly one `mem_we` cycle per word.
- Zero length:
  - Stimulus: 00 00 00 00.
  - Required response: no `mem_we`. DONE one cycle after byte 3, with `words_loaded`=0.
- Over-length:
  - Stimulus: N=`DEPTH`+1 (01 04 00 00 for DEPTH=1024).
  - Required response: `error`=1, `in_ready`=0, `cpu_hold`=1, no writes.
  - Then `restart`=1 gives IDLE, and LEN on the next cycle.
- Reset mid-word:
  - Stimulus: drop `reset` after the 2nd data byte of word 1.
  - Required response: outputs at reset values immediately, with no write of word 1. A full reload afterwards starts at addr 0.
- Boundary:
  - Stimulus: N=`DEPTH`, with `mem_wdata` = word index.
  - Required response: last write at addr `DEPTH`-1, then `done`=1. `restart` during DATA has no effect.

Source files
------------

// File: rtl/imem_loader.sv
// Boot loader for the instruction store: collects a length-prefixed little-endian
// byte stream, writes one 32-bit word per 4 bytes and holds the CPU until the load ends.
module imem_loader #(
  parameter int WORDSIZE = 32,
  parameter int DEPTH    = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                restart,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [WORDSIZE-1:0] mem_wdata,
  output logic [31:0]         words_loaded,
  output logic                done,
  output logic                error,
  output logic                cpu_hold
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_t              state_r;
  logic [1:0]          bidx_r;
  logic [WORDSIZE-1:0] shift_r;
  logic [31:0]         len_r;

  logic                accept_s;
  logic [WORDSIZE-1:0] word_s;
  logic                last_write_s;

  // Handshake decode and the word completed by the byte currently on the bus
  always_comb begin
    accept_s     = in_valid && in_ready;
    word_s       = {in_data, shift_r[WORDSIZE-9:0]};
    last_write_s = mem_we && (mem_addr == (len_r - 32'd1));
  end

  // Loader state machine with registered handshake, write-port and status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= S_IDLE;
      bidx_r       <= 2'd0;
      shift_r      <= {WORDSIZE{1'b0}};
      len_r        <= 32'd0;
      in_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'd0;
      mem_wdata    <= {WORDSIZE{1'b0}};
      words_loaded <= 32'd0;
      done         <= 1'b0;
      error        <= 1'b0;
      cpu_hold     <= 1'b1;
    end else begin
      mem_we <= 1'b0;
      if (mem_we) begin
        words_loaded <= words_loaded + 32'd1;
      end
      if (accept_s) begin
        shift_r[{bidx_r, 3'b000} +: 8] <= in_data;
        bidx_r                         <= bidx_r + 2'd1;
      end
      case (state_r)
        S_IDLE: begin
          state_r  <= S_LEN;
          in_ready <= 1'b1;
        end
        S_LEN: begin
          if (accept_s && (bidx_r == 2'd3)) begin
            len_r <= word_s;
            if (word_s == 32'd0) begin
              state_r  <= S_DONE;
              in_ready <= 1'b0;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else if (word_s > DEPTH_W) begin
              state_r  <= S_ERR;
              in_ready <= 1'b0;
              error    <= 1'b1;
            end else begin
              state_r <= S_DATA;
            end
          end
        end
        S_DATA: begin
          // words_loaded is settled here: the previous write ended at least 3 edges ago
          if (accept_s && (bidx_r == 2'd3)) begin
            mem_we    <= 1'b1;
            mem_addr  <= words_loaded;
            mem_wdata <= word_s;
          end
          if (last_write_s) begin
            state_r  <= S_DONE;
            in_ready <= 1'b0;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end
        end
        S_DONE, S_ERR: begin
          if (restart) begin
            state_r      <= S_IDLE;
            in_ready     <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            cpu_hold     <= 1'b1;
            words_loaded <= 32'd0;
            bidx_r       <= 2'd0;
            len_r        <= 32'd0;
          end
        end
        default: begin
          state_r      <= S_IDLE;
          in_ready     <= 1'b0;
          done         <= 1'b0;
          error        <= 1'b0;
          cpu_hold     <= 1'b1;
          words_loaded <= 32'd0;
          bidx_r       <= 2'd0;
          len_r        <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of load scenarios plus random loads,
// expected writes come from a word list built alongside the byte stream.
module tb_imem_loader;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        restart = 1'b0;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] words_loaded;
  logic        done;
  logic        error;
  logic        cpu_hold;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  bit restart_noise = 1'b0;

  logic [7:0]  stream_q[$];
  logic [31:0] exp_w[$];

  typedef struct {
    logic [31:0] n;
    int          pct;
    int          kind;
    bit          noise;
    bit          exp_done;
    bit          exp_err;
    logic [31:0] exp_words;
  } vec_t;

  vec_t tbl[8];

  imem_loader #(.WORDSIZE(32), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .restart      (restart),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .words_loaded (words_loaded),
    .done         (done),
    .error        (error),
    .cpu_hold     (cpu_hold)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) wr_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: length prefix then N little-endian words; word k goes to address k
  task automatic build(input logic [31:0] n, input int kind);
    logic [31:0] w;
    stream_q.delete();
    exp_w.delete();
    for (int b = 0; b < 4; b++) stream_q.push_back(n[8*b +: 8]);
    if (n <= 32'(DEPTH)) begin
      for (int i = 0; i < int'(n); i++) begin
        case (kind)
          1:       w = (i == 0) ? 32'h0000_0013 : 32'h0010_0093;
          2:       w = 32'(i);
          default: w = $urandom;
        endcase
        exp_w.push_back(w);
        for (int b = 0; b < 4; b++) stream_q.push_back(w[8*b +: 8]);
      end
    end
  endtask

  task automatic drive(input int pct, input int max_bytes, output int cyc);
    int idx;
    int k;
    bit acc;
    idx = 0;
    cyc = 0;
    while (idx < max_bytes && cyc < 50000) begin
      in_data  = stream_q[idx];
      in_valid = ($urandom_range(0, 99) < pct);
      restart  = restart_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      acc      = in_valid && in_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
        if (idx >= 4 && (idx % 4) == 3) begin
          k = (idx - 4) / 4;
          if (k < exp_w.size())
            chk("write", {mem_we, mem_addr[30:0], mem_wdata}, {1'b1, k[30:0], exp_w[k]});
        end
        idx++;
      end
    end
    in_valid = 1'b0;
    restart  = 1'b0;
    if (idx < max_bytes) chk("stream_timeout", 64'(idx), 64'(max_bytes));
  endtask

  task automatic run_vec(input logic [31:0] n, input int pct, input int kind, input bit noise,
                         input bit exp_done, input bit exp_err, input logic [31:0] exp_words);
    int base;
    int cyc;
    base = wr_cnt;
    build(n, kind);
    restart_noise = noise;
    drive(pct, stream_q.size(), cyc);
    restart_noise = 1'b0;
    if (pct >= 100) chk("throughput", 64'(cyc), 64'(stream_q.size()));
    if (exp_w.size() > 0) begin
      chk("done_early", done, 1'b0);
      @(posedge clk);
      #1;
    end
    chk("done", done, exp_done);
    chk("error", error, exp_err);
    chk("cpu_hold", cpu_hold, !exp_done);
    chk("in_ready_end", in_ready, 1'b0);
    chk("words_loaded", words_loaded, exp_words);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("refused", {done, error, in_ready, words_loaded}, {exp_done, exp_err, 1'b0, exp_words});
    chk("write_count", 64'(wr_cnt - base), 64'(exp_w.size()));
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
    chk("idle", {in_ready, done, error, cpu_hold, words_loaded}, {1'b0, 1'b0, 1'b0, 1'b1, 32'd0});
    @(posedge clk);
    #1;
    chk("len", in_ready, 1'b1);
  endtask

  initial begin
    int base;
    int cyc;
    logic [31:0] n;
    bit ok;

    tbl[0] = '{32'd2,          100, 1, 1'b0, 1'b1, 1'b0, 32'd2};
    tbl[1] = '{32'd2,          45,  1, 1'b0, 1'b1, 1'b0, 32'd2};
    tbl[2] = '{32'd0,          100, 0, 1'b0, 1'b1, 1'b0, 32'd0};
    tbl[3] = '{32'd1025,       100, 0, 1'b0, 1'b0, 1'b1, 32'd0};
    tbl[4] = '{32'd7,          60,  0, 1'b1, 1'b1, 1'b0, 32'd7};
    tbl[5] = '{32'd1,          100, 0, 1'b0, 1'b1, 1'b0, 32'd1};
    tbl[6] = '{32'h0100_0000,  80,  0, 1'b0, 1'b0, 1'b1, 32'd0};
    tbl[7] = '{32'd1024,       100, 2, 1'b1, 1'b1, 1'b0, 32'd1024};

    #12;
    chk("reset_ctl", {in_ready, mem_we, done, error, cpu_hold}, 5'b00001);
    chk("reset_addr", mem_addr, 32'd0);
    chk("reset_wdata", mem_wdata, 32'd0);
    chk("reset_words", words_loaded, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("release_idle", in_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("release_len", {in_ready, cpu_hold}, 2'b11);

    for (int i = 0; i < 8; i++)
      run_vec(tbl[i].n, tbl[i].pct, tbl[i].kind, tbl[i].noise,
              tbl[i].exp_done, tbl[i].exp_err, tbl[i].exp_words);

    for (int i = 0; i < 4; i++) begin
      n  = (i == 3) ? 32'(DEPTH + $urandom_range(1, 100000)) : 32'($urandom_range(1, 6));
      ok = (n <= 32'(DEPTH));
      run_vec(n, $urandom_range(20, 100), 0, 1'($urandom_range(0, 1)),
              ok, !ok, ok ? n : 32'd0);
    end

    // Reset dropped after the 2nd byte of word 1
    build(32'd2, 1);
    drive(100, 10, cyc);
    reset = 1'b0;
    #1;
    chk("midrst_ctl", {in_ready, mem_we, done, error, cpu_hold}, 5'b00001);
    chk("midrst_addr", mem_addr, 32'd0);
    chk("midrst_wdata", mem_wdata, 32'd0);
    chk("midrst_words", words_loaded, 32'd0);
    base = wr_cnt;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_no_write", 64'(wr_cnt - base), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_len", in_ready, 1'b1);
    run_vec(32'd2, 100, 1, 1'b0, 1'b1, 1'b0, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
